// File: rtl/if_fetch_unit_if.sv
// Instruction-ROM handshake bundle used by the fetch stage.
//   rom_ce_o    fetch -> ROM   request / enable
//   rom_addr_o  fetch -> ROM   byte address of the requested word
//   rom_inst_i  ROM -> fetch   instruction word, valid while rom_ack_i=1
//   rom_ack_i   ROM -> fetch   current request completes (may be the request cycle)
// master: fetch-unit side; slave: ROM side.
interface if_fetch_unit_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        rom_ack_i;

  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_inst_i,
    input  rom_ack_i
  );

  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_inst_i,
    output rom_ack_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from the instruction
// ROM, captures returned words and presents if_pc/if_inst to IF/ID.
// Handles wait-state ROMs through the ack handshake, the global stall
// vector (only stall[0] is used here) and branch redirects from ID.
//
// Parameters:
//   RESET_PC  PC loaded on reset, first address fetched
//   PC_STEP   sequential PC increment in bytes
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall[5:0]               global stall vector, stall[0] holds the fetch stage
//   branch_flag_i            ID redirect request this cycle
//   branch_target_address_i  redirect target
//   rom                      ROM handshake (if_fetch_unit_if.master)
//   if_pc, if_inst           PC and word of the last delivered instruction
//   stallreq_from_if         fetch outstanding (request issued, no ack yet)
//   if_excp_misalign         misaligned-target exception slot marker
//                            (present only when IF_MISALIGN_CHECK_EN is defined)
// Build option IF_MISALIGN_CHECK_EN: misaligned next PC produces an exception
// slot instead of a ROM request. Without it, the low two address bits are
// forced to zero.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  branch_flag_i,
  input  logic [31:0]           branch_target_address_i,
  if_fetch_unit_if.master       rom,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic                  stallreq_from_if
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                  if_excp_misalign
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] br_tgt;
  logic        pend_br;

  logic [31:0] raw_next_pc;
  logic [31:0] next_pc;
  logic        ack_in;
  logic        advance;
  logic        mis_now;
  logic        mis_wait;

  logic unused_stall;
  assign unused_stall = ^stall[5:1];

`ifdef IF_MISALIGN_CHECK_EN
  // A misaligned PC reaching REQ is reported instead of being fetched.
  assign mis_now        = (state == S_REQ) && (pc[1:0] != 2'b00);
  assign next_pc        = raw_next_pc;
  assign rom.rom_addr_o = pc;
`else
  assign mis_now        = 1'b0;
  assign mis_wait       = 1'b0;
  assign next_pc        = {raw_next_pc[31:2], 2'b00};
  assign rom.rom_addr_o = {pc[31:2], 2'b00};
`endif

  assign rom.rom_ce_o     = (state == S_REQ) && !mis_now;
  assign stallreq_from_if = rom.rom_ce_o && !rom.rom_ack_i;
  assign ack_in           = rom.rom_ce_o && rom.rom_ack_i;

  // A pending (latched) branch takes priority over a live one and over
  // the sequential PC.
  always_comb begin
    raw_next_pc = pend_br ? br_tgt
                          : (branch_flag_i ? branch_target_address_i : pc + PC_STEP);
  end

  // PC advances on an acked fetch without stall, or when leaving HOLD.
  // After a misaligned slot, HOLD only exits on a fresh target.
  always_comb begin
    advance = 1'b0;
    case (state)
      S_REQ:   advance = ack_in && !stall[0];
      S_HOLD:  advance = !stall[0] && (!mis_wait || pend_br || branch_flag_i);
      default: advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      br_tgt  <= '0;
      pend_br <= 1'b0;
      if_pc   <= '0;
      if_inst <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (mis_now) begin
            if_pc   <= pc;
            if_inst <= '0;
            state   <= S_HOLD;
          end else if (ack_in) begin
            if_inst <= rom.rom_inst_i;
            if_pc   <= pc;
            state   <= stall[0] ? S_HOLD : S_REQ;
          end
        end
        S_HOLD: begin
          if (advance) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase

      // Branches that cannot be taken now are remembered; newest wins.
      if (advance) begin
        pc      <= next_pc;
        pend_br <= 1'b0;
      end else if (branch_flag_i) begin
        br_tgt  <= branch_target_address_i;
        pend_br <= 1'b1;
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_excp_misalign <= 1'b0;
      mis_wait         <= 1'b0;
    end else if (mis_now) begin
      if_excp_misalign <= 1'b1;
      mis_wait         <= 1'b1;
    end else begin
      if (ack_in)  if_excp_misalign <= 1'b0;
      if (advance) mis_wait         <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        sreq;
`ifdef IF_MISALIGN_CHECK_EN
  logic        excp;
`endif

  if_fetch_unit_if rom_bus ();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (br),
    .branch_target_address_i (tgt),
    .rom                     (rom_bus),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_from_if        (sreq)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .if_excp_misalign        (excp)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // ROM model: ack after 'lat' waiting cycles, at most 'budget' acks per run.
  int lat = 0;
  int budget = 0;
  int acked = 0;
  int wcnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      acked <= 0;
      wcnt  <= 0;
    end else if (rom_bus.rom_ce_o && rom_bus.rom_ack_i) begin
      acked <= acked + 1;
      wcnt  <= 0;
    end else if (rom_bus.rom_ce_o) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  assign rom_bus.rom_ack_i  = rom_bus.rom_ce_o && (acked < budget) && (wcnt >= lat);
  assign rom_bus.rom_inst_i = rom_bus.rom_ack_i ? rom_word(rom_bus.rom_addr_o) : 32'hDEAD_BEEF;

  // Scoreboard: exp_q holds addresses the bench expects fetched, in order;
  // each acked fetch moves to sb_q and is compared after capture.
  logic [31:0] exp_q[$];
  logic [31:0] sb_q[$];
  bit          chk_pending = 1'b0;

  always begin
    logic [31:0] a;
    @(negedge clk);
    #2;
    if (chk_pending) begin
      a = sb_q.pop_front();
      chk("cap_pc", if_pc, a);
      chk("cap_inst", if_inst, rom_word(a));
      chk_pending = 1'b0;
    end
    if (!rst && rom_bus.rom_ce_o && rom_bus.rom_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_fetch: got addr %h expected no fetch", rom_bus.rom_addr_o);
      end else begin
        a = exp_q.pop_front();
        chk("fetch_addr", rom_bus.rom_addr_o, a);
        sb_q.push_back(a);
        chk_pending = 1'b1;
      end
    end
  end

  typedef struct {
    logic        stall0;
    logic        exp_ce;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_sreq;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(logic s, logic ce, logic ca, logic [31:0] ad, logic sr,
                              logic [31:0] p, logic [31:0] ins);
    vec_t v;
    v.stall0 = s; v.exp_ce = ce; v.chk_addr = ca; v.exp_addr = ad;
    v.exp_sreq = sr; v.exp_pc = p; v.exp_inst = ins;
    return v;
  endfunction

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d_ce", i), {31'b0, rom_bus.rom_ce_o}, {31'b0, vt[i].exp_ce});
      if (vt[i].chk_addr) chk($sformatf("row%0d_addr", i), rom_bus.rom_addr_o, vt[i].exp_addr);
      chk($sformatf("row%0d_sreq", i), {31'b0, sreq}, {31'b0, vt[i].exp_sreq});
      chk($sformatf("row%0d_ifpc", i), if_pc, vt[i].exp_pc);
      chk($sformatf("row%0d_ifinst", i), if_inst, vt[i].exp_inst);
      stall = {5'b0, vt[i].stall0};
    end
  endtask

  // Two reset cycles, reset-state checks, then release; returns at the
  // negedge where rst is dropped (state still IDLE).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = '0; br = 1'b0; tgt = '0;
    budget = 0; lat = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ce", {31'b0, rom_bus.rom_ce_o}, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_ifinst", if_inst, 32'd0);
    chk("rst_sreq", {31'b0, sreq}, 32'd0);
`ifdef IF_MISALIGN_CHECK_EN
    chk("rst_excp", {31'b0, excp}, 32'd0);
`endif
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    #3;
    chk("drain_exp", exp_q.size(), 32'd0);
    chk("drain_sb", sb_q.size() + int'(chk_pending), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w0, w4, w8;
    bit found;
    w0 = rom_word(32'h0);
    w4 = rom_word(32'h4);
    w8 = rom_word(32'h8);

    // zero-wait stream
    vt[0]  = mk(0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
    vt[1]  = mk(0, 1, 1, 32'h4, 0, 32'h0, w0);
    vt[2]  = mk(0, 1, 1, 32'h8, 0, 32'h4, w4);
    vt[3]  = mk(0, 1, 1, 32'hC, 0, 32'h8, w8);
    // two wait states per fetch
    vt[4]  = mk(0, 1, 1, 32'h0, 1, 32'h0, 32'h0);
    vt[5]  = mk(0, 1, 1, 32'h0, 1, 32'h0, 32'h0);
    vt[6]  = mk(0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
    vt[7]  = mk(0, 1, 1, 32'h4, 1, 32'h0, w0);
    vt[8]  = mk(0, 1, 1, 32'h4, 1, 32'h0, w0);
    vt[9]  = mk(0, 1, 1, 32'h4, 0, 32'h0, w0);
    // stall[0] for 4 cycles from the ack at 0x8
    vt[10] = mk(0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
    vt[11] = mk(0, 1, 1, 32'h4, 0, 32'h0, w0);
    vt[12] = mk(1, 1, 1, 32'h8, 0, 32'h4, w4);
    vt[13] = mk(1, 0, 0, 32'h0, 0, 32'h8, w8);
    vt[14] = mk(1, 0, 0, 32'h0, 0, 32'h8, w8);
    vt[15] = mk(1, 0, 0, 32'h0, 0, 32'h8, w8);
    vt[16] = mk(0, 0, 0, 32'h0, 0, 32'h8, w8);
    vt[17] = mk(0, 1, 1, 32'hC, 0, 32'h8, w8);

    // reset and zero-wait fetch
    do_reset();
    lat = 0; budget = 4;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run_table(0, 3);
    drain();

    // wait states
    do_reset();
    lat = 2; budget = 2;
    exp_q = '{32'h0, 32'h4};
    run_table(4, 9);
    drain();

    // stall hold and resume
    do_reset();
    lat = 0; budget = 4;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run_table(10, 17);
    drain();

    // branch while REQ@0x10 is unacked: 0x10 still delivered, then 0x100
    do_reset();
    lat = 0; budget = 4;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100};
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rom_bus.rom_ce_o && rom_bus.rom_addr_o == 32'h10) found = 1'b1;
    end
    chk("wait_req10", {31'b0, found}, 32'd1);
    chk("br_sreq", {31'b0, sreq}, 32'd1);
    br = 1'b1; tgt = 32'h100;
    @(negedge clk);
    br = 1'b0;
    chk("br_hold_addr", rom_bus.rom_addr_o, 32'h10);
    budget = 6;
    @(negedge clk);
    chk("br_new_ce", {31'b0, rom_bus.rom_ce_o}, 32'd1);
    chk("br_new_addr", rom_bus.rom_addr_o, 32'h100);
    drain();

    // misaligned branch target
    do_reset();
    lat = 0; budget = 1;
`ifdef IF_MISALIGN_CHECK_EN
    exp_q = '{32'h0};
`else
    budget = 2;
    exp_q = '{32'h0, 32'h100};
`endif
    @(negedge clk);
    br = 1'b1; tgt = 32'h102;
    @(negedge clk);
    br = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_ce0", {31'b0, rom_bus.rom_ce_o}, 32'd0);
    @(negedge clk);
    chk("mis_excp", {31'b0, excp}, 32'd1);
    chk("mis_inst", if_inst, 32'd0);
    chk("mis_pc", if_pc, 32'h102);
    chk("mis_ce1", {31'b0, rom_bus.rom_ce_o}, 32'd0);
    @(negedge clk);
    chk("mis_wait_ce", {31'b0, rom_bus.rom_ce_o}, 32'd0);
    budget = 2; exp_q.push_back(32'h200);
    br = 1'b1; tgt = 32'h200;
    @(negedge clk);
    br = 1'b0;
    chk("mis_redir_addr", rom_bus.rom_addr_o, 32'h200);
    @(negedge clk);
    chk("mis_excp_clr", {31'b0, excp}, 32'd0);
`else
    chk("align_ce", {31'b0, rom_bus.rom_ce_o}, 32'd1);
    chk("align_addr", rom_bus.rom_addr_o, 32'h100);
`endif
    drain();

    // reset while a fetch is outstanding
    do_reset();
    lat = 0; budget = 2;
    exp_q = '{32'h0, 32'h4};
    @(negedge clk);
    chk("rmid_addr0", rom_bus.rom_addr_o, 32'h0);
    @(posedge clk);
    #1 lat = 3;
    @(negedge clk);
    chk("rmid_sreq", {31'b0, sreq}, 32'd1);
    chk("rmid_inst", if_inst, w0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_ce", {31'b0, rom_bus.rom_ce_o}, 32'd0);
    chk("rmid_sreq0", {31'b0, sreq}, 32'd0);
    chk("rmid_ifpc", if_pc, 32'd0);
    chk("rmid_ifinst", if_inst, 32'd0);
    budget = 0;
    exp_q.delete();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
